// File: rtl/serial_word_driver_if.sv
// Handshake and serial-stream bundle between a word source, the driver and a bit-serial consumer.
// Latency: none; wires only.
// Backpressure: the source holds a word until ready; stall freezes the serial stream.
interface serial_word_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             stall;
  logic             ready;
  logic             x;
  logic             bit_valid;
  logic             last;
  logic             ovr;

  // Word source / stream consumer side
  modport master (
    output din, load, stall,
    input  ready, x, bit_valid, last, ovr
  );

  // Driver side
  modport slave (
    input  din, load, stall,
    output ready, x, bit_valid, last, ovr
  );
endinterface

// File: rtl/serial_word_driver.sv
// Parallel-to-serial word driver: shifts a WIDTH-bit word out MSB-first on x, one bit per clock.
// Latency: first bit on x the cycle after the load is accepted; back-to-back words run with no gap bit.
// Backpressure: ready low rejects load (ovr pulses next cycle); stall freezes the bit stream in place.
module serial_word_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_word_driver_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             ready_c;

  assign at_last = (cnt == LAST_CNT);

  // A new word fits when idle, or when the final bit of the current word leaves this cycle.
  always_comb begin
    ready_c = (state == IDLE) || ((state == SHIFT) && at_last && !bus.stall);
  end

  // Stream outputs come from registered state only; stall merely withholds the qualifier.
  assign bus.ready     = ready_c;
  assign bus.x         = (state == SHIFT) ? sr[WIDTH-1] : 1'b0;
  assign bus.bit_valid = (state == SHIFT) && !bus.stall;
  assign bus.last      = (state == SHIFT) && at_last;

  // Control FSM, shift register, bit counter and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      bus.ovr <= 1'b0;
    end else begin
      // A rejected request is only flagged; it never touches sr, cnt or state.
      bus.ovr <= bus.load && !ready_c;
      case (state)
        IDLE: begin
          if (bus.load) begin
            sr    <= bus.din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus.stall) begin
            if (!at_last) begin
              sr  <= sr << 1;
              cnt <= cnt + CW'(1);
            end else if (bus.load) begin
              // Next word's MSB follows the current LSB directly.
              sr  <= bus.din;
              cnt <= '0;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_driver.sv
// Self-checking bench for serial_word_driver: cycle vectors plus a bit-stream scoreboard.
// Latency: checks first bit one cycle after acceptance and gap-free back-to-back words.
// Backpressure: exercises stall, rejected loads (ovr) and reset mid-word.
module tb_serial_word_driver;
  localparam int W = 8;

  typedef struct {
    logic         rst;
    logic         load;
    logic         stall;
    logic [W-1:0] din;
    logic         e_ready;
    logic         e_x;
    logic         e_bv;
    logic         e_last;
    logic         e_ovr;
  } vec_t;

  typedef struct {
    logic x;
    logic last;
  } bit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_word_driver_if #(.WIDTH(W)) bus ();

  serial_word_driver #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  bit_t exp_q[$];

  // Reference model of the driver's handshake, updated once per cycle
  logic m_busy = 1'b0;
  int   m_cnt  = 0;
  logic m_ovr  = 1'b0;
  logic m_rdy;
  int   m_acc  = 0;
  bit_t e;

  // Downstream "1011" overlapping detector fed by DUT bits and by expected bits
  logic [3:0] dut_hist = '0;
  logic [3:0] ref_hist = '0;
  int         dut_hits = 0;
  int         ref_hits = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic l, input logic s, input logic [W-1:0] d,
                     input logic er, input logic ex, input logic ebv, input logic el,
                     input logic eo);
    vec_t v;
    v.rst = r; v.load = l; v.stall = s; v.din = d;
    v.e_ready = er; v.e_x = ex; v.e_bv = ebv; v.e_last = el; v.e_ovr = eo;
    vecs.push_back(v);
  endtask

  // Unstalled bits hi..lo of word w; ready and last only on bit 0
  task automatic add_bits(input logic [W-1:0] w, input int hi, input int lo);
    for (int b = hi; b >= lo; b--)
      add(1'b0, 1'b0, 1'b0, '0, (b == 0), w[b], 1'b1, (b == 0), 1'b0);
  endtask

  task automatic add_idle();
    add(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive(input logic r, input logic l, input logic s, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    rst = r; bus.load = l; bus.stall = s; bus.din = d;
  endtask

  // Scoreboard monitor: checks handshake against the model and pops expected bits
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0; m_cnt = 0; m_ovr = 1'b0;
      dut_hist = '0; ref_hist = '0;
    end else begin
      m_rdy = !m_busy || ((m_cnt == W - 1) && !bus.stall);
      chk("mon.ready", 16'(bus.ready), 16'(m_rdy));
      chk("mon.ovr", 16'(bus.ovr), 16'(m_ovr));
      chk("mon.bit_valid", 16'(bus.bit_valid), 16'(m_busy && !bus.stall));
      if (m_busy && !bus.stall) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mon.underrun got=bit want=no_bit at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("mon.x", 16'(bus.x), 16'(e.x));
          chk("mon.last", 16'(bus.last), 16'(e.last));
          dut_hist = {dut_hist[2:0], bus.x};
          ref_hist = {ref_hist[2:0], e.x};
          if (dut_hist == 4'b1011) dut_hits++;
          if (ref_hist == 4'b1011) ref_hits++;
        end
      end
      if (bus.load && m_rdy) begin
        for (int i = W - 1; i >= 0; i--) begin
          e.x = bus.din[i];
          e.last = (i == 0);
          exp_q.push_back(e);
        end
        m_acc++;
      end
      m_ovr = bus.load && !m_rdy;
      if (m_busy) begin
        if (!bus.stall) begin
          if (m_cnt < W - 1) m_cnt++;
          else if (bus.load) m_cnt = 0;
          else m_busy = 1'b0;
        end
      end else if (bus.load) begin
        m_busy = 1'b1;
        m_cnt = 0;
      end
    end
  end

  initial begin
    int base;
    int cyc;
    bus.load = 1'b0; bus.stall = 1'b0; bus.din = '0;

    // Reset state, then single word 8'hB4
    add_idle();
    add(1'b0, 1'b1, 1'b0, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hB4, 7, 0);
    add_idle();
    // Back-to-back F0 then 0F, load on F0's last bit
    add(1'b0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hF0, 7, 1);
    add(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_bits(8'h0F, 7, 0);
    add_idle();
    // Overrun while shifting AA
    add(1'b0, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hAA, 7, 6);
    add(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    add_bits(8'hAA, 3, 0);
    add_idle();
    // Stall mid-word on C3 for three cycles holding bit 5
    add(1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hC3, 7, 6);
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'hC3, 5, 0);
    add_idle();
    // Stall on the last bit: ready drops, a load there is rejected
    add(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'h01, 7, 1);
    add(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    add_idle();
    // Reset mid-word on 5A overrides a concurrent (would-be rejected) load
    add(1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'h5A, 7, 5);
    add(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_idle();
    // Load in idle is accepted even with stall high
    add(1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(8'h81, 7, 0);
    add_idle();

    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].stall, vecs[i].din);
      @(negedge clk);
      chk($sformatf("vec%0d.ready", i), 16'(bus.ready), 16'(vecs[i].e_ready));
      chk($sformatf("vec%0d.x", i), 16'(bus.x), 16'(vecs[i].e_x));
      chk($sformatf("vec%0d.bit_valid", i), 16'(bus.bit_valid), 16'(vecs[i].e_bv));
      chk($sformatf("vec%0d.last", i), 16'(bus.last), 16'(vecs[i].e_last));
      chk($sformatf("vec%0d.ovr", i), 16'(bus.ovr), 16'(vecs[i].e_ovr));
    end

    // Random words, random stall, frequent load attempts, rare reset
    base = m_acc;
    cyc = 0;
    while ((m_acc - base) < 200 && cyc < 20000) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0), W'($urandom));
      cyc++;
    end
    chk("rand.words_accepted", 16'((m_acc - base) >= 200), 16'(1));

    for (int k = 0; k < 12; k++) drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("drain.queue_empty", 16'(exp_q.size()), 16'(0));
    chk("drain.bit_valid", 16'(bus.bit_valid), 16'(0));
    chk("drain.ready", 16'(bus.ready), 16'(1));
    chk("detector.hits", 16'(dut_hits), 16'(ref_hits));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
